// File: rtl/button_event_ctrl.sv
// Per-button press classifier (SHORT / LONG / REPEAT) feeding a round-robin
// arbiter and a small event FIFO with a sticky overflow flag.
module button_event_ctrl #(
  parameter int unsigned NUM_BTN    = 4,
  parameter int unsigned LONG_MS    = 1000,
  parameter int unsigned REPEAT_MS  = 200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick_1khz,
  input  logic [NUM_BTN-1:0]              btn_rise,
  input  logic [NUM_BTN-1:0]              btn_fall,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [$clog2(NUM_BTN)-1:0]      evt_id,
  output logic [1:0]                      evt_code,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  input  logic                            clr_overflow
);

  localparam int unsigned IDW     = $clog2(NUM_BTN);
  localparam int unsigned CNT_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0]  LONG_LAST   = CW'(LONG_MS - 1);
  localparam logic [CW-1:0]  REPEAT_LAST = CW'(REPEAT_MS - 1);
  localparam logic [IDW-1:0] RR_LAST     = IDW'(NUM_BTN - 1);
  localparam logic [PW-1:0]  PTR_LAST    = PW'(FIFO_DEPTH - 1);
  localparam logic [FCW-1:0] CNT_FULL    = FCW'(FIFO_DEPTH);

  localparam logic [1:0] CODE_SHORT  = 2'b00;
  localparam logic [1:0] CODE_LONG   = 2'b01;
  localparam logic [1:0] CODE_REPEAT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } state_t;

  state_t           state_q     [NUM_BTN];
  state_t           state_d     [NUM_BTN];
  logic [CW-1:0]    cnt_q       [NUM_BTN];
  logic [CW-1:0]    cnt_d       [NUM_BTN];
  logic [1:0]       pend_code_q [NUM_BTN];
  logic [1:0]       pend_code_d [NUM_BTN];
  logic [1:0]       gen_code    [NUM_BTN];
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic [NUM_BTN-1:0] gen;

  logic [IDW-1:0]   rr_q, rr_d;
  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;

  logic [IDW-1:0]   fifo_id_q   [FIFO_DEPTH];
  logic [IDW-1:0]   fifo_id_d   [FIFO_DEPTH];
  logic [1:0]       fifo_code_q [FIFO_DEPTH];
  logic [1:0]       fifo_code_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [FCW-1:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             pop;
  logic             full;

  assign evt_valid  = (count_q != '0);
  assign evt_id     = evt_valid ? fifo_id_q[rd_q]   : '0;
  assign evt_code   = evt_valid ? fifo_code_q[rd_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  assign pop  = evt_valid && evt_ready;
  assign full = (count_q == CNT_FULL);

  // Per-button FSM; a coincident rise+fall freezes the button entirely,
  // and release takes priority over a terminal tick in HELD.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BTN; b++) begin
      state_d[b]  = state_q[b];
      cnt_d[b]    = cnt_q[b];
      gen[b]      = 1'b0;
      gen_code[b] = CODE_SHORT;
      if (!(btn_rise[b] && btn_fall[b])) begin
        case (state_q[b])
          ST_IDLE: begin
            if (btn_rise[b]) begin
              state_d[b] = ST_HELD;
              cnt_d[b]   = '0;
            end
          end
          ST_HELD: begin
            if (btn_fall[b]) begin
              gen[b]      = 1'b1;
              gen_code[b] = CODE_SHORT;
              state_d[b]  = ST_IDLE;
              cnt_d[b]    = '0;
            end else if (tick_1khz) begin
              if (cnt_q[b] == LONG_LAST) begin
                gen[b]      = 1'b1;
                gen_code[b] = CODE_LONG;
                state_d[b]  = ST_LONG;
                cnt_d[b]    = '0;
              end else begin
                cnt_d[b] = cnt_q[b] + CW'(1);
              end
            end
          end
          ST_LONG: begin
            if (btn_fall[b]) begin
              state_d[b] = ST_IDLE;
              cnt_d[b]   = '0;
            end else if (tick_1khz) begin
              if (cnt_q[b] == REPEAT_LAST) begin
                gen[b]      = 1'b1;
                gen_code[b] = CODE_REPEAT;
                cnt_d[b]    = '0;
              end else begin
                cnt_d[b] = cnt_q[b] + CW'(1);
              end
            end
          end
          default: begin
            state_d[b] = ST_IDLE;
            cnt_d[b]   = '0;
          end
        endcase
      end
    end
  end

  // Round-robin search starting at rr_q; a full FIFO may still accept
  // when the consumer pops in the same cycle.
  always_comb begin
    int unsigned j;
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_BTN) j = j - NUM_BTN;
      if (!grant_vld && (!full || pop) && pend_q[j]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(j);
      end
    end
    if (grant_vld) rr_d = (grant_idx == RR_LAST) ? '0 : grant_idx + IDW'(1);
    else           rr_d = rr_q;
  end

  // Pending slots: a grant frees the slot in time for a same-cycle event.
  always_comb begin
    logic ovf_set;
    ovf_set = 1'b0;
    for (int unsigned b = 0; b < NUM_BTN; b++) begin
      pend_d[b]      = pend_q[b];
      pend_code_d[b] = pend_code_q[b];
      if (grant_vld && (grant_idx == IDW'(b))) pend_d[b] = 1'b0;
      if (gen[b]) begin
        if (pend_q[b] && !(grant_vld && (grant_idx == IDW'(b)))) begin
          ovf_set = 1'b1;
        end else begin
          pend_d[b]      = 1'b1;
          pend_code_d[b] = gen_code[b];
        end
      end
    end
    if (ovf_set)           overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
  end

  always_comb begin
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      fifo_id_d[k]   = fifo_id_q[k];
      fifo_code_d[k] = fifo_code_q[k];
    end
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (grant_vld) begin
      fifo_id_d[wr_q]   = grant_idx;
      fifo_code_d[wr_q] = pend_code_q[grant_idx];
      wr_d              = (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
    end
    if (pop) rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
    case ({grant_vld, pop})
      2'b10:   count_d = count_q + FCW'(1);
      2'b01:   count_d = count_q - FCW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < NUM_BTN; b++) begin
        state_q[b]     <= ST_IDLE;
        cnt_q[b]       <= '0;
        pend_code_q[b] <= '0;
      end
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        fifo_id_q[k]   <= '0;
        fifo_code_q[k] <= '0;
      end
      pend_q     <= '0;
      rr_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned b = 0; b < NUM_BTN; b++) begin
        state_q[b]     <= state_d[b];
        cnt_q[b]       <= cnt_d[b];
        pend_code_q[b] <= pend_code_d[b];
      end
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        fifo_id_q[k]   <= fifo_id_d[k];
        fifo_code_q[k] <= fifo_code_d[k];
      end
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with LONG_MS=10, REPEAT_MS=3,
// FIFO_DEPTH=4; expected values are hand-derived cycle by cycle.
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1khz;
  logic [3:0] btn_rise;
  logic [3:0] btn_fall;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_code;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clr_overflow;

  int checks   = 0;
  int failures = 0;

  button_event_ctrl #(
    .NUM_BTN    (4),
    .LONG_MS    (10),
    .REPEAT_MS  (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1khz    (tick_1khz),
    .btn_rise     (btn_rise),
    .btn_fall     (btn_fall),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .evt_code     (evt_code),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] f, input logic t);
    btn_rise  = r;
    btn_fall  = f;
    tick_1khz = t;
    cyc();
    btn_rise  = '0;
    btn_fall  = '0;
    tick_1khz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 4'b0000, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [1:0] id, input logic [1:0] code);
    check_eq({tag, "_valid"}, 32'(evt_valid), 32'd1);
    check_eq({tag, "_id"},    32'(evt_id),    32'(id));
    check_eq({tag, "_code"},  32'(evt_code),  32'(code));
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    tick_1khz    = 1'b0;
    btn_rise     = '0;
    btn_fall     = '0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    cyc();
    check_eq("rst_valid", 32'(evt_valid),  32'd0);
    check_eq("rst_id",    32'(evt_id),     32'd0);
    check_eq("rst_code",  32'(evt_code),   32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_ovf",   32'(overflow),   32'd0);
    cyc();
    rst = 1'b0;

    // Short press on btn0: valid two clocks after the release cycle.
    drive(4'b0001, 4'b0000, 1'b0);
    ticks(5);
    drive(4'b0000, 4'b0001, 1'b0);
    check_eq("short_n1_valid", 32'(evt_valid), 32'd0);
    cyc();
    check_eq("short_n2_count", 32'(fifo_count), 32'd1);
    pop_check("short", 2'd0, 2'b00);
    check_eq("short_empty", 32'(fifo_count), 32'd0);

    // Long hold on btn1 for 19 ticks.
    drive(4'b0010, 4'b0000, 1'b0);
    ticks(9);
    cyc();
    cyc();
    check_eq("long_before10", 32'(fifo_count), 32'd0);
    ticks(1);
    cyc();
    check_eq("long_at10_valid", 32'(evt_valid), 32'd1);
    check_eq("long_at10_code",  32'(evt_code),  32'd1);
    ticks(9);
    drive(4'b0000, 4'b0010, 1'b0);
    cyc();
    cyc();
    check_eq("long_count", 32'(fifo_count), 32'd4);
    check_eq("long_ovf",   32'(overflow),   32'd0);
    pop_check("long_e0", 2'd1, 2'b01);
    pop_check("long_e1", 2'd1, 2'b10);
    pop_check("long_e2", 2'd1, 2'b10);
    pop_check("long_e3", 2'd1, 2'b10);
    cyc();
    cyc();
    check_eq("long_release_none", 32'(fifo_count), 32'd0);

    // Round robin: four simultaneous SHORTs drained with evt_ready held.
    do_reset();
    drive(4'b1111, 4'b0000, 1'b0);
    drive(4'b0000, 4'b1111, 1'b0);
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check_eq("rr_valid", 32'(evt_valid),  32'd1);
      check_eq("rr_id",    32'(evt_id),     32'(k));
      check_eq("rr_count", 32'(fifo_count), 32'd1);
    end
    cyc();
    check_eq("rr_drained", 32'(fifo_count), 32'd0);
    evt_ready = 1'b0;
    // rr back at 0: btn0 must win over btn3.
    drive(4'b1001, 4'b0000, 1'b0);
    drive(4'b0000, 4'b1001, 1'b0);
    cyc();
    cyc();
    check_eq("rr_wrap_count", 32'(fifo_count), 32'd2);
    pop_check("rr_wrap_a", 2'd0, 2'b00);
    pop_check("rr_wrap_b", 2'd3, 2'b00);

    // FIFO full, pending slot and overflow.
    drive(4'b1111, 4'b0000, 1'b0);
    drive(4'b0000, 4'b1111, 1'b0);
    cyc();
    cyc();
    cyc();
    cyc();
    check_eq("full_count", 32'(fifo_count), 32'd4);
    drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0100, 1'b0);
    cyc();
    check_eq("full_5th_count", 32'(fifo_count), 32'd4);
    check_eq("full_5th_ovf",   32'(overflow),   32'd0);
    drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0100, 1'b0);
    check_eq("full_6th_ovf", 32'(overflow), 32'd1);
    pop_check("full_p0", 2'd0, 2'b00);
    check_eq("full_pushpop_count", 32'(fifo_count), 32'd4);
    pop_check("full_p1", 2'd1, 2'b00);
    pop_check("full_p2", 2'd2, 2'b00);
    pop_check("full_p3", 2'd3, 2'b00);
    pop_check("full_p4", 2'd2, 2'b00);
    check_eq("full_drained", 32'(fifo_count), 32'd0);
    check_eq("ovf_sticky",   32'(overflow),   32'd1);
    clr_overflow = 1'b1;
    cyc();
    clr_overflow = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'd0);

    // Reset mid-hold with an entry queued.
    drive(4'b0010, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0010, 1'b0);
    drive(4'b0001, 4'b0000, 1'b0);
    ticks(7);
    check_eq("mid_pre_count", 32'(fifo_count), 32'd1);
    check_eq("mid_pre_id",    32'(evt_id),     32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(evt_valid),  32'd0);
    check_eq("mid_rst_id",    32'(evt_id),     32'd0);
    check_eq("mid_rst_code",  32'(evt_code),   32'd0);
    check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
    check_eq("mid_rst_ovf",   32'(overflow),   32'd0);
    cyc();
    rst = 1'b0;
    ticks(12);
    drive(4'b0000, 4'b0001, 1'b0);
    cyc();
    cyc();
    check_eq("mid_no_event", 32'(fifo_count), 32'd0);
    drive(4'b0001, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0001, 1'b0);
    cyc();
    check_eq("mid_new_press", 32'(fifo_count), 32'd1);
    pop_check("mid_new", 2'd0, 2'b00);

    // Release coincident with the 10th tick yields SHORT only.
    drive(4'b1000, 4'b0000, 1'b0);
    ticks(9);
    drive(4'b0000, 4'b1000, 1'b1);
    cyc();
    check_eq("coin_count", 32'(fifo_count), 32'd1);
    pop_check("coin", 2'd3, 2'b00);
    ticks(12);
    cyc();
    check_eq("coin_no_long", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 The block SHALL provide the following parameters:
- NUM_BTN, default 4: number of debounced buttons served.
- LONG_MS, default 1000: hold time in ticks before a LONG event.
- REPEAT_MS, default 200: interval in ticks between REPEAT events while held long.
- FIFO_DEPTH, default 4: event queue depth (power of 2).

REQ-002 The block SHALL provide the following ports:
- clk  in  1: system clock.
- rst  in  1: reset, asynchronous, active-high.
- tick_1khz  in  1: one-clk-wide timebase strobe.
- btn_rise  in  NUM_BTN: per-button debounced press pulse.
- btn_fall  in  NUM_BTN: per-button debounced release pulse.
- evt_valid  out  1: FIFO head entry valid.
- evt_ready  in  1: consumer accepts head entry.
- evt_id  out  clog2(NUM_BTN): button index of head entry.
- evt_code  out  2: head entry type; 00 SHORT, 01 LONG, 10 REPEAT, 11 unused.
- fifo_count  out  clog2(FIFO_DEPTH)+1: entries held.
- overflow  out  1: sticky event-lost flag.
- clr_overflow  in  1: clears overflow.

Function
REQ-003 Each button SHALL have an independent FSM with states IDLE, HELD, LONG and a hold counter wide enough for max(LONG_MS, REPEAT_MS).
REQ-004 IDLE: btn_rise -> HELD, counter=0; btn_fall ignored.
REQ-005 HELD:
- Each tick_1khz increments the counter.
- On a tick with counter==LONG_MS-1: generate LONG, go to LONG, counter=0.
- On btn_fall: generate SHORT, go to IDLE.
REQ-006 LONG:
- Each tick increments the counter.
- On a tick with counter==REPEAT_MS-1: generate REPEAT, counter=0.
- On btn_fall: go to IDLE; no event is generated.
REQ-007 If btn_fall and a terminal tick occur in the same cycle in HELD, the block SHALL generate SHORT only and go to IDLE.
REQ-008 If btn_rise and btn_fall are both asserted for one button in the same cycle, the block SHALL make no state change for that button.
REQ-009 A generated event SHALL be latched into a one-entry per-button pending register (code) at the clock edge ending the generating cycle.
REQ-010 If a button generates an event while its pending register is still occupied, the new event SHALL be dropped and overflow SHALL be set.
REQ-011 A round-robin arbiter SHALL transfer at most one pending entry per cycle into the FIFO:
- Search starts at pointer rr.
- After a grant to button k, rr=(k+1) mod NUM_BTN.
- With no grant, rr holds.
REQ-012 A grant SHALL occur only when the FIFO is not full, or when it is full and a pop happens in the same cycle.
REQ-013 A granted entry's pending register SHALL clear in the grant cycle; a new event from that button in the same cycle SHALL be latched and not dropped.
REQ-014 Pop SHALL occur when evt_valid && evt_ready; evt_ready while empty has no effect.
REQ-015 evt_valid SHALL equal (fifo_count!=0); evt_id/evt_code SHALL present the head entry and be 0 when empty.
REQ-016 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or underflow.
REQ-017 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-018 Latency SHALL be exactly 2 clocks: event generated in cycle N, no contention, empty FIFO -> evt_valid=1 in cycle N+2.
REQ-019 overflow SHALL set per REQ-010 and SHALL clear only on clr_overflow or rst; if set and clear coincide, set wins.
REQ-020 Events from one button SHALL reach the consumer in generation order.

Reset
REQ-021 On rst, the block SHALL immediately force:
- all FSMs to IDLE;
- counters, pending registers and rr to 0;
- FIFO empty, so evt_valid=0, evt_id=0, evt_code=0, fifo_count=0;
- overflow=0.
REQ-022 Reset asserted mid-hold SHALL discard all state; after release, a button already held SHALL produce no event until a new btn_rise.

Verification
REQ-023 The bench SHALL cover the following directed scenarios (LONG_MS=10, REPEAT_MS=3, FIFO_DEPTH=4):
- Short press: rise btn0, fall after 5 ticks -> one entry id=0 code=00, evt_valid high 2 clocks after the fall.
- Long hold with repeats: rise btn1, hold 19 ticks, release -> LONG at tick 10, REPEAT at ticks 13, 16, 19, no event on release; count=4.
- Round robin: btn0..btn3 fall in the same cycle from HELD, evt_ready=1 -> ids delivered 0,1,2,3 in consecutive cycles; rr=0 afterward.
- FIFO full: evt_ready=0, 4 SHORT events from btn0-3 then a 5th from btn2 -> fifo_count=4, btn2 pending; 6th from btn2 -> overflow=1; pop one -> pending btn2 enters same cycle, count stays 4.
- Reset mid-hold: btn0 in HELD at count 7, pulse rst -> all outputs 0; release produces no event.
- Edge cases: fall coincident with the 10th tick -> SHORT only; clr_overflow pulse -> overflow=0 next clock.
